// File: rtl/instr_boot_loader.sv
// instr_boot_loader: buffers a program word stream, bursts it into the CPU, then pulses CPU reset.
// Optional XOR checksum of accepted words is built only with LOADER_CHECKSUM_EN defined.
module instr_boot_loader #(
  parameter int MAX_WORDS      = 32,
  parameter int CPU_RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        LoadInstructions,
  output logic [31:0] Instruction,
  output logic        CpuReset,
  output logic        busy,
  output logic        done,
  output logic [8:0]  word_count,
  output logic        err_overflow,
  output logic [31:0] checksum
);
  localparam int AW = $clog2(MAX_WORDS);
  typedef enum logic [2:0] {IDLE, FILL, BURST, RSTPULSE, RUN} state_t;
  state_t          state_q, state_d;
  logic [8:0]      word_count_q, word_count_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [3:0]      rst_cnt_q, rst_cnt_d;
  logic            err_q, err_d;
  logic [31:0]     buf_q [MAX_WORDS];
  logic            xfer, clear, full;
  assign xfer  = state_q == FILL && in_valid;
  assign clear = (state_q == IDLE || state_q == RUN) && start;
  assign full  = word_count_q + 9'd1 == 9'(MAX_WORDS);
  always_comb begin
    state_d      = state_q;
    word_count_d = clear ? 9'd0 : word_count_q + 9'(xfer);
    rd_idx_d     = state_q == BURST ? rd_idx_q + AW'(1) : '0;
    rst_cnt_d    = state_q == RSTPULSE ? rst_cnt_q + 4'd1 : 4'd0;
    err_d        = clear ? 1'b0 : err_q || (xfer && !in_last && full);
    unique case (state_q)
      IDLE, RUN: if (start) state_d = FILL;
      FILL:      if (xfer && (in_last || full)) state_d = BURST;
      BURST:     if (9'(rd_idx_q) == word_count_q - 9'd1) state_d = RSTPULSE;
      RSTPULSE:  if (rst_cnt_q == 4'(CPU_RST_CYCLES - 1)) state_d = RUN;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      rd_idx_q     <= '0;
      rst_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      rd_idx_q     <= rd_idx_d;
      rst_cnt_q    <= rst_cnt_d;
      err_q        <= err_d;
    end
  end
  // program storage deliberately has no reset
  always_ff @(posedge clk) begin
    if (xfer) buf_q[word_count_q[AW-1:0]] <= in_data;
  end
  assign in_ready         = state_q == FILL;
  assign LoadInstructions = state_q == BURST;
  assign Instruction      = LoadInstructions ? buf_q[rd_idx_q] : 32'd0;
  assign CpuReset         = state_q == IDLE || state_q == FILL || state_q == RSTPULSE;
  assign busy             = state_q == FILL || state_q == BURST || state_q == RSTPULSE;
  assign done             = state_q == RUN;
  assign word_count       = word_count_q;
  assign err_overflow     = err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;
  assign checksum_d = clear ? 32'd0 : xfer ? checksum_q ^ in_data : checksum_q;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif
endmodule
